// File: rtl/byte_packetizer_pkg.sv
// Shared types and helpers for the byte-to-packet receiver.
// Used by byte_packetizer_rx and b2p_out_reg.
package byte_packetizer_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        ASSEMBLE = 1'b1
    } b2p_state_e;

    // Maps the arrival index of a byte within a symbol to its byte lane (lane 0 = bits [7:0]).
    function automatic int unsigned lane_index(input int unsigned idx,
                                               input int unsigned n_lanes,
                                               input bit          msb_first);
        return msb_first ? (n_lanes - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/b2p_out_reg.sv
// One-deep output holding register with ready/valid and packet sideband.
// The error sideband exists only when B2P_TIMEOUT_EN is defined.
module b2p_out_reg
    import byte_packetizer_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_sop,
    input  logic              i_eop,
`ifdef B2P_TIMEOUT_EN
    input  logic              i_err,
    output logic              o_err,
`endif
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_sop,
    output logic              o_eop
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_sop;
    logic              r_eop;
`ifdef B2P_TIMEOUT_EN
    logic              r_err;
`endif

    // The producer only loads when the register is empty or draining this cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
`ifdef B2P_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_sop   <= i_sop;
            r_eop   <= i_eop;
`ifdef B2P_TIMEOUT_EN
            r_err   <= i_err;
`endif
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_sop   = r_sop;
    assign o_eop   = r_eop;
`ifdef B2P_TIMEOUT_EN
    assign o_err   = r_err;
`endif

endmodule

// File: rtl/byte_packetizer_rx.sv
// Gathers bytes into symbols and frames them into Avalon-ST packets of run-time length.
// Define B2P_TIMEOUT_EN to flush stalled packets with an error-flagged EOP symbol.
module byte_packetizer_rx
    import byte_packetizer_pkg::*;
#(
    parameter int BYTES_PER_SYMBOL = 4,
    parameter int BITS_PER_BYTES   = 8,
    parameter int LEN_W            = 8,
    parameter int MSB_FIRST        = 1
`ifdef B2P_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES   = 1024
`endif
) (
    input  logic                                   clock_clk,
    input  logic                                   reset_reset_n,
    input  logic [LEN_W-1:0]                       cfg_pkt_len,
    input  logic [BITS_PER_BYTES-1:0]              asi_in0_data,
    input  logic                                   asi_in0_valid,
    output logic                                   asi_in0_ready,
    output logic [BYTES_PER_SYMBOL*BITS_PER_BYTES-1:0] aso_out0_data,
    output logic                                   aso_out0_valid,
    input  logic                                   aso_out0_ready,
    output logic                                   aso_out0_startofpacket,
    output logic                                   aso_out0_endofpacket
`ifdef B2P_TIMEOUT_EN
    ,
    output logic                                   aso_out0_error
`endif
);

    localparam int DATA_W = BYTES_PER_SYMBOL * BITS_PER_BYTES;
    localparam int BC_W   = (BYTES_PER_SYMBOL > 1) ? $clog2(BYTES_PER_SYMBOL) : 1;

    b2p_state_e        r_state, w_state_next;
    logic [BC_W-1:0]   r_byte_cnt, w_byte_cnt_next;
    logic [LEN_W-1:0]  r_sym_cnt, w_sym_cnt_next;
    logic [LEN_W-1:0]  r_len, w_len_next;
    logic [DATA_W-1:0] r_sym, w_sym_buf_next;

    logic [LEN_W-1:0]  w_len;
    logic [DATA_W-1:0] w_sym_next;
    logic [DATA_W-1:0] w_load_data;
    logic              w_last_byte, w_accept, w_eop;
    logic              w_load, w_load_sop, w_load_eop;

`ifdef B2P_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] r_idle_cnt, w_idle_cnt_next;
    logic              w_flush_pending, w_flush_fire, w_load_err;

    assign w_flush_pending = (r_state == ASSEMBLE) &&
                             (r_idle_cnt == IDLE_W'(TIMEOUT_CYCLES));
    assign w_flush_fire    = w_flush_pending && (!aso_out0_valid || aso_out0_ready);
`endif

    assign w_last_byte = (r_byte_cnt == BC_W'(BYTES_PER_SYMBOL - 1));
`ifdef B2P_TIMEOUT_EN
    assign asi_in0_ready = (!w_last_byte || !aso_out0_valid || aso_out0_ready) &&
                           !w_flush_pending;
`else
    assign asi_in0_ready = !w_last_byte || !aso_out0_valid || aso_out0_ready;
`endif
    assign w_accept = asi_in0_valid && asi_in0_ready;

    // The first byte of a packet sees cfg_pkt_len directly, so single-symbol packets frame correctly.
    assign w_len = (r_state == IDLE) ? ((cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len) : r_len;
    assign w_eop = (r_sym_cnt == w_len - LEN_W'(1));

    always_comb begin
        w_sym_next = (r_byte_cnt == '0) ? '0 : r_sym;
        for (int unsigned l = 0; l < BYTES_PER_SYMBOL; l++) begin
            if (l == lane_index(int'(r_byte_cnt), BYTES_PER_SYMBOL, MSB_FIRST != 0)) begin
                w_sym_next[l*BITS_PER_BYTES +: BITS_PER_BYTES] = asi_in0_data;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_byte_cnt_next = r_byte_cnt;
        w_sym_cnt_next  = r_sym_cnt;
        w_len_next      = r_len;
        w_sym_buf_next  = r_sym;
        w_load          = 1'b0;
        w_load_sop      = 1'b0;
        w_load_eop      = 1'b0;
        w_load_data     = w_sym_next;
`ifdef B2P_TIMEOUT_EN
        w_load_err      = 1'b0;
        w_idle_cnt_next = r_idle_cnt;
        if (r_state == IDLE || w_accept) begin
            w_idle_cnt_next = '0;
        end else if (!w_flush_pending) begin
            w_idle_cnt_next = r_idle_cnt + IDLE_W'(1);
        end
`endif
        if (w_accept) begin
            w_sym_buf_next = w_sym_next;
            if (r_state == IDLE) begin
                w_state_next = ASSEMBLE;
                w_len_next   = w_len;
            end
            if (w_last_byte) begin
                w_load          = 1'b1;
                w_load_sop      = (r_sym_cnt == '0);
                w_load_eop      = w_eop;
                w_byte_cnt_next = '0;
                if (w_eop) begin
                    w_sym_cnt_next = '0;
                    w_state_next   = IDLE;
                end else begin
                    w_sym_cnt_next = r_sym_cnt + LEN_W'(1);
                end
            end else begin
                w_byte_cnt_next = r_byte_cnt + BC_W'(1);
            end
        end
`ifdef B2P_TIMEOUT_EN
        else if (w_flush_fire) begin
            // Keep collected lanes; a symbol with no bytes yet flushes as all zero.
            w_load          = 1'b1;
            w_load_data     = (r_byte_cnt == '0) ? '0 : r_sym;
            w_load_sop      = (r_sym_cnt == '0);
            w_load_eop      = 1'b1;
            w_load_err      = 1'b1;
            w_byte_cnt_next = '0;
            w_sym_cnt_next  = '0;
            w_idle_cnt_next = '0;
            w_state_next    = IDLE;
        end
`endif
    end

    always_ff @(posedge clock_clk) begin
        if (!reset_reset_n) begin
            r_state    <= IDLE;
            r_byte_cnt <= '0;
            r_sym_cnt  <= '0;
            r_len      <= LEN_W'(1);
            r_sym      <= '0;
`ifdef B2P_TIMEOUT_EN
            r_idle_cnt <= '0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_sym_cnt  <= w_sym_cnt_next;
            r_len      <= w_len_next;
            r_sym      <= w_sym_buf_next;
`ifdef B2P_TIMEOUT_EN
            r_idle_cnt <= w_idle_cnt_next;
`endif
        end
    end

    b2p_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .i_clk   (clock_clk),
        .i_rst_n (reset_reset_n),
        .i_load  (w_load),
        .i_data  (w_load_data),
        .i_sop   (w_load_sop),
        .i_eop   (w_load_eop),
`ifdef B2P_TIMEOUT_EN
        .i_err   (w_load_err),
        .o_err   (aso_out0_error),
`endif
        .i_ready (aso_out0_ready),
        .o_valid (aso_out0_valid),
        .o_data  (aso_out0_data),
        .o_sop   (aso_out0_startofpacket),
        .o_eop   (aso_out0_endofpacket)
    );

endmodule

// File: tb/tb_byte_packetizer_rx.sv
// Directed bench for byte_packetizer_rx: MSB-first and LSB-first instances share one stimulus.
// The timeout flush section is built only when B2P_TIMEOUT_EN is defined.
module tb_byte_packetizer_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cfg_len;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready, in_ready_lsb;
    logic [31:0] out_data, out_data_lsb;
    logic        out_valid, out_valid_lsb;
    logic        out_ready;
    logic        out_sop, out_eop, out_sop_lsb, out_eop_lsb;
    logic        out_err;
`ifdef B2P_TIMEOUT_EN
    logic        out_err_lsb;
`else
    assign out_err = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_stall  = 0;

    logic [31:0] q_data[$];
    logic [2:0]  q_flag[$];  // {err, sop, eop}
    logic [31:0] q_lsb[$];

    always #5 clk = ~clk;

    byte_packetizer_rx #(
        .BYTES_PER_SYMBOL (4),
        .BITS_PER_BYTES   (8),
        .LEN_W            (8),
        .MSB_FIRST        (1)
`ifdef B2P_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES   (16)
`endif
    ) dut (
        .clock_clk              (clk),
        .reset_reset_n          (rst_n),
        .cfg_pkt_len            (cfg_len),
        .asi_in0_data           (in_data),
        .asi_in0_valid          (in_valid),
        .asi_in0_ready          (in_ready),
        .aso_out0_data          (out_data),
        .aso_out0_valid         (out_valid),
        .aso_out0_ready         (out_ready),
        .aso_out0_startofpacket (out_sop),
        .aso_out0_endofpacket   (out_eop)
`ifdef B2P_TIMEOUT_EN
        ,
        .aso_out0_error         (out_err)
`endif
    );

    byte_packetizer_rx #(
        .BYTES_PER_SYMBOL (4),
        .BITS_PER_BYTES   (8),
        .LEN_W            (8),
        .MSB_FIRST        (0)
`ifdef B2P_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES   (16)
`endif
    ) dut_lsb (
        .clock_clk              (clk),
        .reset_reset_n          (rst_n),
        .cfg_pkt_len            (cfg_len),
        .asi_in0_data           (in_data),
        .asi_in0_valid          (in_valid),
        .asi_in0_ready          (in_ready_lsb),
        .aso_out0_data          (out_data_lsb),
        .aso_out0_valid         (out_valid_lsb),
        .aso_out0_ready         (out_ready),
        .aso_out0_startofpacket (out_sop_lsb),
        .aso_out0_endofpacket   (out_eop_lsb)
`ifdef B2P_TIMEOUT_EN
        ,
        .aso_out0_error         (out_err_lsb)
`endif
    );

    // Record output handshakes and input stalls mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_flag.push_back({out_err, out_sop, out_eop});
        end
        if (rst_n && out_valid_lsb && out_ready) q_lsb.push_back(out_data_lsb);
        if (rst_n && in_valid && !in_ready) n_stall++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_sym(input string tag, input int idx, input logic [31:0] data,
                             input logic sop, input logic eop);
        if (idx < q_data.size()) begin
            check({tag, "_data"}, 64'(q_data[idx]), 64'(data));
            check({tag, "_sop"}, 64'(q_flag[idx][1]), 64'(sop));
            check({tag, "_eop"}, 64'(q_flag[idx][0]), 64'(eop));
`ifdef B2P_TIMEOUT_EN
            check({tag, "_err"}, 64'(q_flag[idx][2]), 64'(1'b0));
`endif
        end else begin
            check({tag, "_present"}, 64'(q_data.size()), 64'(idx + 1));
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            tick(1);
            n++;
        end
        if (n >= 50) check("send_ready_bound", 64'(in_ready), 64'(1'b1));
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic send_run(input logic [7:0] first, input int count);
        for (int i = 0; i < count; i++) send_byte(first + 8'(i));
    endtask

    task automatic clear_q();
        q_data.delete();
        q_flag.delete();
        q_lsb.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_len   = 8'd3;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(1);

        // Reset state
        check("rst_valid", 64'(out_valid), 64'(1'b0));
        check("rst_sop", 64'(out_sop), 64'(1'b0));
        check("rst_eop", 64'(out_eop), 64'(1'b0));
        check("rst_data", 64'(out_data), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1'b1));

        // Back-to-back 12 bytes, len 3
        n_stall = 0;
        send_run(8'h00, 12);
        tick(3);
        check("b2b_count", 64'(q_data.size()), 64'(3));
        check_sym("b2b_s0", 0, 32'h00010203, 1'b1, 1'b0);
        check_sym("b2b_s1", 1, 32'h04050607, 1'b0, 1'b0);
        check_sym("b2b_s2", 2, 32'h08090A0B, 1'b0, 1'b1);
        check("b2b_no_stall", 64'(n_stall), 64'(0));
        if (q_lsb.size() > 0) check("lsb_s0", 64'(q_lsb[0]), 64'(32'h03020100));
        else check("lsb_s0_present", 64'(q_lsb.size()), 64'(1));

        // Backpressure: output stalled while byte 7 waits
        clear_q();
        out_ready = 1'b0;
        send_run(8'h20, 7);
        in_valid = 1'b1;
        in_data  = 8'h27;
        #1;
        check("bp_in_ready_low", 64'(in_ready), 64'(1'b0));
        check("bp_valid", 64'(out_valid), 64'(1'b1));
        check("bp_data", 64'(out_data), 64'(32'h20212223));
        check("bp_sop", 64'(out_sop), 64'(1'b1));
        tick(7);
        check("bp_in_ready_still_low", 64'(in_ready), 64'(1'b0));
        check("bp_data_held", 64'(out_data), 64'(32'h20212223));
        check("bp_sop_held", 64'(out_sop), 64'(1'b1));
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_up", 64'(in_ready), 64'(1'b1));
        tick(1);
        in_valid = 1'b0;
        send_run(8'h28, 4);
        tick(3);
        check("bp_count", 64'(q_data.size()), 64'(3));
        check_sym("bp_s0", 0, 32'h20212223, 1'b1, 1'b0);
        check_sym("bp_s1", 1, 32'h24252627, 1'b0, 1'b0);
        check_sym("bp_s2", 2, 32'h28292A2B, 1'b0, 1'b1);
        if (q_lsb.size() > 1) check("bp_lsb_s1", 64'(q_lsb[1]), 64'(32'h27262524));
        else check("bp_lsb_present", 64'(q_lsb.size()), 64'(3));

        // Length change mid-packet takes effect on the next packet
        clear_q();
        cfg_len = 8'd3;
        send_byte(8'h30);
        cfg_len = 8'd2;
        send_run(8'h31, 11);
        send_run(8'h40, 8);
        tick(3);
        check("len_count", 64'(q_data.size()), 64'(5));
        check_sym("len_p0s0", 0, 32'h30313233, 1'b1, 1'b0);
        check_sym("len_p0s1", 1, 32'h34353637, 1'b0, 1'b0);
        check_sym("len_p0s2", 2, 32'h38393A3B, 1'b0, 1'b1);
        check_sym("len_p1s0", 3, 32'h40414243, 1'b1, 1'b0);
        check_sym("len_p1s1", 4, 32'h44454647, 1'b0, 1'b1);

        // Length 0 behaves as 1
        clear_q();
        cfg_len = 8'd0;
        send_run(8'h50, 8);
        tick(3);
        check("len0_count", 64'(q_data.size()), 64'(2));
        check_sym("len0_s0", 0, 32'h50515253, 1'b1, 1'b1);
        check_sym("len0_s1", 1, 32'h54555657, 1'b1, 1'b1);

        // Reset mid-packet with a symbol held in the output register
        cfg_len   = 8'd3;
        out_ready = 1'b0;
        send_run(8'h60, 6);
        check("pre_rst_valid", 64'(out_valid), 64'(1'b1));
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_valid", 64'(out_valid), 64'(1'b0));
        check("mid_rst_data", 64'(out_data), 64'(0));
        check("mid_rst_sop", 64'(out_sop), 64'(1'b0));
        check("mid_rst_eop", 64'(out_eop), 64'(1'b0));
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick(1);
        check("post_rst_in_ready", 64'(in_ready), 64'(1'b1));
        clear_q();
        send_run(8'h70, 12);
        tick(3);
        check("post_rst_count", 64'(q_data.size()), 64'(3));
        check_sym("post_rst_s0", 0, 32'h70717273, 1'b1, 1'b0);
        check_sym("post_rst_s1", 1, 32'h74757677, 1'b0, 1'b0);
        check_sym("post_rst_s2", 2, 32'h78797A7B, 1'b0, 1'b1);

`ifdef B2P_TIMEOUT_EN
        // Stalled packet: counter reaches 16 after 16 idle edges, flush loads on the next edge
        begin
            int cnt;
            clear_q();
            cfg_len = 8'd3;
            send_run(8'h00, 5);
            cnt = 0;
            while (!(out_valid && out_err) && cnt < 64) begin
                tick(1);
                cnt++;
            end
            check("to_latency", 64'(cnt), 64'(17));
            check("to_data", 64'(out_data), 64'(32'h04000000));
            check("to_sop", 64'(out_sop), 64'(1'b0));
            check("to_eop", 64'(out_eop), 64'(1'b1));
            check("to_err", 64'(out_err), 64'(1'b1));
            tick(2);
            check("to_in_ready_after", 64'(in_ready), 64'(1'b1));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
